// File: rtl/id_ex_pkg.sv
// id_ex_pkg: control-bundle layout, default widths and counter saturation value for id_ex_stage.
package id_ex_pkg;
  localparam int CTRL_W_DEF      = 12;
  localparam int MEMREAD_BIT_DEF = 3;
  localparam int CB_REGWRITE     = 0;
  localparam int CB_MEMTOREG     = 1;
  localparam int CB_MEMWRITE     = 2;
  localparam int CB_MEMREAD      = MEMREAD_BIT_DEF;
  localparam int CB_ALUSRC       = 4;
  localparam int CB_REGDST       = 5;
  localparam int CB_BRANCH       = 6;
  localparam int CB_ALUOP_LSB    = 7;
  localparam int CB_ALUOP_MSB    = 8;
  localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard check; a flushed ID instruction never stalls.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  output logic       stall
);
  logic hazard;
  assign hazard = ex_valid & ex_memread & id_valid & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign stall = hazard & ~flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and saturating stall counter.
// Define ID_EX_WB_BYPASS_EN to forward same-edge WB writes into the captured operands.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int MEMREAD_BIT = MEMREAD_BIT_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              IdValid,
  input  logic [4:0]        RsIn,
  input  logic [4:0]        RtIn,
  input  logic [4:0]        RdIn,
  input  logic [31:0]       ReadData1In,
  input  logic [31:0]       ReadData2In,
  input  logic [31:0]       ImmIn,
  input  logic [31:0]       PCPlus4In,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic              Flush,
  input  logic              WbRegWrite,
  input  logic [4:0]        WbWriteRegister,
  input  logic [31:0]       WbWriteData,
  output logic              ValidOut,
  output logic [4:0]        RsOut,
  output logic [4:0]        RtOut,
  output logic [4:0]        RdOut,
  output logic [31:0]       ReadData1Out,
  output logic [31:0]       ReadData2Out,
  output logic [31:0]       ImmOut,
  output logic [31:0]       PCPlus4Out,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic              Stall,
  output logic [31:0]       StallCount
);
  logic [31:0] rd1_n, rd2_n;
`ifdef ID_EX_WB_BYPASS_EN
  logic wb_hit;
  assign wb_hit = WbRegWrite & (WbWriteRegister != 5'd0);
  assign rd1_n  = (wb_hit && WbWriteRegister == RsIn) ? WbWriteData : ReadData1In;
  assign rd2_n  = (wb_hit && WbWriteRegister == RtIn) ? WbWriteData : ReadData2In;
`else
  logic unused_wb;
  assign unused_wb = ^{WbRegWrite, WbWriteRegister, WbWriteData};
  assign rd1_n     = ReadData1In;
  assign rd2_n     = ReadData2In;
`endif
  load_use_detect u_lud (
    .ex_valid  (ValidOut),
    .ex_memread(CtrlOut[MEMREAD_BIT]),
    .ex_rt     (RtOut),
    .id_valid  (IdValid),
    .id_rs     (RsIn),
    .id_rt     (RtIn),
    .flush     (Flush),
    .stall     (Stall)
  );
  always_ff @(posedge Clk) begin
    if (!Rst_n || Flush || Stall) begin
      ValidOut     <= 1'b0;
      RsOut        <= '0;
      RtOut        <= '0;
      RdOut        <= '0;
      ReadData1Out <= '0;
      ReadData2Out <= '0;
      ImmOut       <= '0;
      PCPlus4Out   <= '0;
      CtrlOut      <= '0;
    end else begin
      ValidOut     <= IdValid;
      RsOut        <= RsIn;
      RtOut        <= RtIn;
      RdOut        <= RdIn;
      ReadData1Out <= rd1_n;
      ReadData2Out <= rd2_n;
      ImmOut       <= ImmIn;
      PCPlus4Out   <= PCPlus4In;
      CtrlOut      <= IdValid ? CtrlIn : '0;
    end
    if (!Rst_n) StallCount <= '0;
    else if (Stall && StallCount != STALL_SAT) StallCount <= StallCount + 32'd1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors feed a scoreboard queue; a monitor pops and checks each cycle.
module tb_id_ex_stage;
  localparam logic [11:0] C_ADD = 12'h121;
  localparam logic [11:0] C_LW  = 12'h01B;
  typedef struct {
    logic        cs;
    logic        stall;
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [11:0] ctrl;
    logic [31:0] cnt;
  } exp_t;
  logic        Clk, Rst_n, IdValid, Flush, WbRegWrite;
  logic [4:0]  RsIn, RtIn, RdIn, WbWriteRegister;
  logic [31:0] ReadData1In, ReadData2In, ImmIn, PCPlus4In, WbWriteData;
  logic [11:0] CtrlIn;
  logic        ValidOut, Stall;
  logic [4:0]  RsOut, RtOut, RdOut;
  logic [31:0] ReadData1Out, ReadData2Out, ImmOut, PCPlus4Out, StallCount;
  logic [11:0] CtrlOut;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .IdValid(IdValid), .RsIn(RsIn), .RtIn(RtIn), .RdIn(RdIn),
    .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .ImmIn(ImmIn), .PCPlus4In(PCPlus4In),
    .CtrlIn(CtrlIn), .Flush(Flush), .WbRegWrite(WbRegWrite), .WbWriteRegister(WbWriteRegister),
    .WbWriteData(WbWriteData), .ValidOut(ValidOut), .RsOut(RsOut), .RtOut(RtOut), .RdOut(RdOut),
    .ReadData1Out(ReadData1Out), .ReadData2Out(ReadData2Out), .ImmOut(ImmOut),
    .PCPlus4Out(PCPlus4Out), .CtrlOut(CtrlOut), .Stall(Stall), .StallCount(StallCount)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, iv, input logic [4:0] rs, rt, rd,
                       input logic [31:0] d1, d2, imm, pc, input logic [11:0] ctrl, input logic fl);
    Rst_n = rst; IdValid = iv; RsIn = rs; RtIn = rt; RdIn = rd;
    ReadData1In = d1; ReadData2In = d2; ImmIn = imm; PCPlus4In = pc; CtrlIn = ctrl; Flush = fl;
  endtask

  task automatic expect_out(input logic cs, es, ev, input logic [4:0] rs, rt, rd,
                            input logic [31:0] d1, d2, imm, pc, input logic [11:0] ctrl, input logic [31:0] cnt);
    exp_t e;
    e.cs = cs; e.stall = es; e.v = ev; e.rs = rs; e.rt = rt; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.imm = imm; e.pc = pc; e.ctrl = ctrl; e.cnt = cnt;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic expect_bubble(input logic cs, es, input logic [31:0] cnt);
    expect_out(cs, es, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'd0, cnt);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.cs) chk("stall", {31'd0, Stall}, {31'd0, e.stall});
        @(posedge Clk);
        #1;
        chk("valid", {31'd0, ValidOut}, {31'd0, e.v});
        chk("rs", {27'd0, RsOut}, {27'd0, e.rs});
        chk("rt", {27'd0, RtOut}, {27'd0, e.rt});
        chk("rd", {27'd0, RdOut}, {27'd0, e.rd});
        chk("rdata1", ReadData1Out, e.d1);
        chk("rdata2", ReadData2Out, e.d2);
        chk("imm", ImmOut, e.imm);
        chk("pcplus4", PCPlus4Out, e.pc);
        chk("ctrl", {20'd0, CtrlOut}, {20'd0, e.ctrl});
        chk("stall_count", StallCount, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp;
    drive(0, 1, 5'd9, 5'd9, 5'd9, 32'd1, 32'd2, 32'd3, 32'd4, C_LW, 0);
    WbRegWrite = 0; WbWriteRegister = 0; WbWriteData = 0;
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
            $urandom, $urandom, 12'($urandom), 1'($urandom));
      expect_bubble(i != 0, 1'b0, 32'd0);
    end
    drive(1, 1, 8, 9, 10, 32'h10, 32'h20, 32'hFFFFFFFC, 32'h100, C_ADD, 0);
    expect_out(1, 0, 1, 8, 9, 10, 32'h10, 32'h20, 32'hFFFFFFFC, 32'h100, C_ADD, 0);
    drive(1, 1, 8, 9, 0, 32'h1000, 32'h0, 32'h4, 32'h104, C_LW, 0);
    expect_out(1, 0, 1, 8, 9, 0, 32'h1000, 32'h0, 32'h4, 32'h104, C_LW, 0);
    drive(1, 1, 9, 3, 11, 32'h55, 32'h66, 32'h0, 32'h108, C_ADD, 0);
    expect_bubble(1, 1, 32'd1);
    expect_out(1, 0, 1, 9, 3, 11, 32'h55, 32'h66, 32'h0, 32'h108, C_ADD, 1);
    drive(1, 1, 0, 0, 0, 32'h2000, 32'h0, 32'h8, 32'h10C, C_LW, 0);
    expect_out(1, 0, 1, 0, 0, 0, 32'h2000, 32'h0, 32'h8, 32'h10C, C_LW, 1);
    drive(1, 1, 0, 0, 12, 32'h0, 32'h0, 32'h0, 32'h110, C_ADD, 0);
    expect_out(1, 0, 1, 0, 0, 12, 32'h0, 32'h0, 32'h0, 32'h110, C_ADD, 1);
    drive(1, 1, 4, 7, 0, 32'h3000, 32'h0, 32'hC, 32'h114, C_LW, 0);
    expect_out(1, 0, 1, 4, 7, 0, 32'h3000, 32'h0, 32'hC, 32'h114, C_LW, 1);
    drive(1, 1, 2, 7, 13, 32'h77, 32'h88, 32'h0, 32'h118, C_ADD, 1);
    expect_bubble(1, 0, 32'd1);
    drive(1, 0, 1, 2, 3, 32'hAA, 32'hBB, 32'h5, 32'h11C, C_ADD, 0);
    expect_out(1, 0, 0, 1, 2, 3, 32'hAA, 32'hBB, 32'h5, 32'h11C, 12'd0, 1);
`ifdef ID_EX_WB_BYPASS_EN
    bp = 32'hCAFE;
`else
    bp = 32'h0;
`endif
    drive(1, 1, 6, 5, 14, 32'h11, 32'h0, 32'h0, 32'h120, C_ADD, 0);
    WbRegWrite = 1; WbWriteRegister = 5; WbWriteData = 32'hCAFE;
    expect_out(1, 0, 1, 6, 5, 14, 32'h11, bp, 32'h0, 32'h120, C_ADD, 1);
    WbRegWrite = 0; WbWriteRegister = 0; WbWriteData = 0;
    force dut.StallCount = 32'hFFFFFFFE;
    #1;
    release dut.StallCount;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 9, 0, 32'h40, 32'h0, 32'h0, 32'h200, C_LW, 0);
      expect_out(1, 0, 1, 1, 9, 0, 32'h40, 32'h0, 32'h0, 32'h200, C_LW, i == 0 ? 32'hFFFFFFFE : 32'hFFFFFFFF);
      drive(1, 1, 9, 2, 4, 32'h50, 32'h60, 32'h0, 32'h204, C_ADD, 0);
      expect_bubble(1, 1, 32'hFFFFFFFF);
      expect_out(1, 0, 1, 9, 2, 4, 32'h50, 32'h60, 32'h0, 32'h204, C_ADD, 32'hFFFFFFFF);
    end
    drive(1, 1, 1, 9, 0, 32'h40, 32'h0, 32'h0, 32'h200, C_LW, 0);
    expect_out(1, 0, 1, 1, 9, 0, 32'h40, 32'h0, 32'h0, 32'h200, C_LW, 32'hFFFFFFFF);
    drive(0, 1, 9, 2, 4, 32'h50, 32'h60, 32'h0, 32'h204, C_ADD, 0);
    expect_bubble(0, 0, 32'd0);
    drive(1, 1, 9, 2, 4, 32'h50, 32'h60, 32'h0, 32'h204, C_ADD, 0);
    expect_out(1, 0, 1, 9, 2, 4, 32'h50, 32'h60, 32'h0, 32'h204, C_ADD, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge Clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
